// File: rtl/uart_pkg.sv
// Shared UART definitions, used by the receiver, the transmitter and the
// receive FIFO so that all of them agree on the character width.
package uart_pkg;

    // Width of one UART character.
    localparam int UART_DATA_W = 8;

    // Width and ceiling of the saturating dropped-byte counter.
    localparam int                 OVF_CNT_W   = 8;
    localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = '1;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// Byte storage for the UART receive FIFO. Synchronous write and asynchronous
// read, so the head entry appears on rdata_o without waiting for a clock.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   we_i,
    input  logic [AW-1:0]          waddr_i,
    input  logic [UART_DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]          raddr_i,
    output logic [UART_DATA_W-1:0] rdata_o
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];

    // Write port: store the incoming byte at the write index.
    // NOTE: the array has no reset. Its contents are only ever read behind a
    // valid pointer range, so clearing it would cost logic and buy nothing.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: first-word-fall-through byte queue
// with a fill-level interrupt, synchronous flush and a sticky overrun flag
// plus saturating count of bytes dropped while the queue was full.
// DEPTH must be a power of two, at least 2.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic                   cfg_flush,
    input  logic [AW:0]            cfg_thresh,
    input  logic                   ovf_clear,
    output logic                   out_valid,
    output logic [UART_DATA_W-1:0] out_data,
    input  logic                   out_ready,
    output logic [AW:0]            fifo_count,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic                   ovf,
    output logic [OVF_CNT_W-1:0]   ovf_cnt,
    output logic                   irq_thresh
);

    // Pointers carry one wrap bit: equal pointers mean empty, pointers that
    // differ only in the wrap bit mean full.
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

    logic [AW:0]          wptr_q, wptr_d;
    logic [AW:0]          rptr_q, rptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    logic pop;
    logic push;
    logic drop;
    logic mem_we;

    // Status comes only from registered state; nothing bypasses the array.
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = ((wptr_q ^ rptr_q) == FULL_XOR);
    assign out_valid  = !fifo_empty;
    assign fifo_count = count_q;
    assign ovf        = ovf_q;
    assign ovf_cnt    = ovf_cnt_q;

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign pop    = out_valid && out_ready;
    assign push   = rx_valid && (!fifo_full || pop);
    assign drop   = rx_valid && fifo_full && !pop && !cfg_flush;
    assign mem_we = push && !cfg_flush;

    // A threshold above DEPTH can never be reached, so it never fires.
    assign irq_thresh = (cfg_thresh != '0) && (count_q >= cfg_thresh);

    uart_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wptr_q[AW-1:0]),
        .wdata_i (rx_data),
        .raddr_i (rptr_q[AW-1:0]),
        .rdata_o (out_data)
    );

    // Next pointers and occupancy; flush wins over any same-cycle push or pop.
    // NOTE: every output of this block is given its hold value first, so no
    // path through the branches can leave a signal unassigned (no latches).
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (cfg_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PTR_ONE;
            if (pop)  rptr_d = rptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + PTR_ONE;
                2'b01:   count_d = count_q - PTR_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Next overrun state; a clear coinciding with a drop records that drop.
    always_comb begin
        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_clear) begin
            ovf_d     = drop;
            ovf_cnt_d = drop ? OVF_CNT_W'(1) : '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (ovf_cnt_q != OVF_CNT_MAX) ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. A queue-based model tracks the
// contents, overrun flag and drop count; each test task compares the DUT
// against it (and against fixed expected values for the directed cases).
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           rx_valid;
    logic [7:0]     rx_data;
    logic           cfg_flush;
    logic [AW:0]    cfg_thresh;
    logic           ovf_clear;
    logic           out_valid;
    logic [7:0]     out_data;
    logic           out_ready;
    logic [AW:0]    fifo_count;
    logic           fifo_full;
    logic           fifo_empty;
    logic           ovf;
    logic [7:0]     ovf_cnt;
    logic           irq_thresh;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [7:0] mq[$];
    bit         m_ovf;
    int         m_cnt;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .cfg_flush  (cfg_flush),
        .cfg_thresh (cfg_thresh),
        .ovf_clear  (ovf_clear),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .ovf        (ovf),
        .ovf_cnt    (ovf_cnt),
        .irq_thresh (irq_thresh)
    );

    always #5 clk = ~clk;

    // One clock cycle: apply inputs, advance the model, wait past the edge.
    task automatic step(input bit v, input logic [7:0] d, input bit rdy,
                        input bit fl, input bit clr);
        bit full, pop, drop;
        rx_valid  = v;
        rx_data   = d;
        out_ready = rdy;
        cfg_flush = fl;
        ovf_clear = clr;
        full = (mq.size() == DEPTH);
        pop  = rdy && (mq.size() != 0);
        drop = v && full && !pop && !fl;
        if (fl) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (v && (!full || pop)) mq.push_back(d);
        end
        if (clr) begin
            m_ovf = drop;
            m_cnt = drop ? 1 : 0;
        end else if (drop) begin
            m_ovf = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
        @(posedge clk);
        #1;
        rx_valid  = 1'b0;
        out_ready = 1'b0;
        cfg_flush = 1'b0;
        ovf_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx_valid = 1'b0; rx_data = '0; cfg_flush = 1'b0; ovf_clear = 1'b0;
        out_ready = 1'b0; cfg_thresh = 5'd1;
        mq.delete(); m_ovf = 1'b0; m_cnt = 0;
        #2;
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", fifo_empty); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", fifo_full); end
        checks++; if (irq_thresh !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq_thresh); end
        checks++; if (ovf !== 1'b0 || ovf_cnt !== 8'd0) begin errors++; $display("FAIL reset_ovf: got %b/%0d want 0/0", ovf, ovf_cnt); end
        @(negedge clk);
        rst = 1'b1;
        cfg_thresh = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL basic_data: got %h want 55", out_data); end
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", fifo_count); end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL basic_hold: got %h want 55", out_data); end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL basic_empty: got %b want 1", fifo_empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", fifo_full); end
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d want 16", fifo_count); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        checks++; if (ovf_cnt !== 8'd2) begin errors++; $display("FAIL ovf_cnt: got %0d want 2", ovf_cnt); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(i)) begin errors++; $display("FAIL ovf_drain[%0d]: got %b/%h want 1/%h", i, out_valid, out_data, 8'(i)); end
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL ovf_drained: got %b want 1", fifo_empty); end
    endtask

    task automatic test_full_pop();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++; if (ovf !== 1'b0 || ovf_cnt !== 8'd0) begin errors++; $display("FAIL clr: got %b/%0d want 0/0", ovf, ovf_cnt); end
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        checks++; if (fifo_count !== 5'd16 || fifo_full !== 1'b1) begin errors++; $display("FAIL fullpop_count: got %0d want 16", fifo_count); end
        checks++; if (out_data !== 8'h01) begin errors++; $display("FAIL fullpop_head: got %h want 01", out_data); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %b want 0", ovf); end
        for (int i = 1; i < DEPTH; i++) begin
            checks++; if (out_data !== 8'(i)) begin errors++; $display("FAIL fullpop_drain[%0d]: got %h want %h", i, out_data, 8'(i)); end
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (fifo_count !== 5'd1 || out_data !== 8'h77) begin errors++; $display("FAIL fullpop_last: got %0d/%h want 1/77", fifo_count, out_data); end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_thresh();
        cfg_thresh = 5'd4;
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        checks++; if (irq_thresh !== 1'b0) begin errors++; $display("FAIL thr_below: got %b want 0", irq_thresh); end
        step(1'b1, 8'h13, 1'b0, 1'b0, 1'b0);
        checks++; if (irq_thresh !== 1'b1) begin errors++; $display("FAIL thr_reach: got %b want 1", irq_thresh); end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (irq_thresh !== 1'b0) begin errors++; $display("FAIL thr_pop: got %b want 0", irq_thresh); end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        cfg_thresh = 5'd0;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            checks++; if (irq_thresh !== 1'b0) begin errors++; $display("FAIL thr_zero[%0d]: got %b want 0", i, irq_thresh); end
        end
        cfg_thresh = 5'd17;
        #1;
        checks++; if (irq_thresh !== 1'b0) begin errors++; $display("FAIL thr_above: got %b want 0", irq_thresh); end
        cfg_thresh = 5'd16;
        #1;
        checks++; if (irq_thresh !== 1'b1) begin errors++; $display("FAIL thr_full: got %b want 1", irq_thresh); end
        cfg_thresh = 5'd0;
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_flush_clear();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (fifo_count !== 5'd5 || ovf !== 1'b1) begin errors++; $display("FAIL fl_setup: got %0d/%b want 5/1", fifo_count, ovf); end
        step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        checks++; if (fifo_count !== 5'd0 || fifo_empty !== 1'b1) begin errors++; $display("FAIL fl_count: got %0d want 0", fifo_count); end
        checks++; if (ovf !== 1'b1 || ovf_cnt !== 8'd1) begin errors++; $display("FAIL fl_ovf: got %b/%0d want 1/1", ovf, ovf_cnt); end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++; if (ovf !== 1'b0 || ovf_cnt !== 8'd0) begin errors++; $display("FAIL fl_clr: got %b/%0d want 0/0", ovf, ovf_cnt); end
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hCC, 1'b0, 1'b0, 1'b1);
        checks++; if (ovf !== 1'b1 || ovf_cnt !== 8'd1) begin errors++; $display("FAIL clr_and_drop: got %b/%0d want 1/1", ovf, ovf_cnt); end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        checks++; if (fifo_count !== 5'd7) begin errors++; $display("FAIL rm_setup: got %0d want 7", fifo_count); end
        #2;
        rst = 1'b0;
        mq.delete(); m_ovf = 1'b0; m_cnt = 0;
        #1;
        checks++; if (fifo_count !== 5'd0 || fifo_empty !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rm_async: got %0d/%b want 0/1", fifo_count, fifo_empty); end
        #2;
        rst = 1'b1;
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C || fifo_count !== 5'd1) begin errors++; $display("FAIL rm_push: got %b/%h/%0d want 1/3c/1", out_valid, out_data, fifo_count); end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom);
            step(1'b1, b, 1'b0, 1'b0, 1'b0);
            checks++; if (out_valid !== 1'b1 || out_data !== b) begin errors++; $display("FAIL wrap[%0d]: got %b/%h want 1/%h", i, out_valid, out_data, b); end
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", fifo_empty); end
    endtask

    task automatic test_random();
        bit v, rdy, fl, clr;
        bit e_irq;
        for (int i = 0; i < 600; i++) begin
            if (i % 64 == 0) cfg_thresh = 5'($urandom_range(0, 31));
            v   = ($urandom_range(0, 3) != 0);
            rdy = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 79) == 0);
            clr = ($urandom_range(0, 39) == 0);
            step(v, 8'($urandom), rdy, fl, clr);
            e_irq = (cfg_thresh != 0) && (mq.size() >= int'(cfg_thresh));
            checks++; if (fifo_count !== 5'(mq.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, fifo_count, mq.size()); end
            checks++; if (out_valid !== (mq.size() != 0) || fifo_full !== (mq.size() == DEPTH)) begin errors++; $display("FAIL rnd_status[%0d]: got v%b f%b want size %0d", i, out_valid, fifo_full, mq.size()); end
            if (mq.size() != 0) begin
                checks++; if (out_data !== mq[0]) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", i, out_data, mq[0]); end
            end
            checks++; if (ovf !== m_ovf || ovf_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL rnd_ovf[%0d]: got %b/%0d want %b/%0d", i, ovf, ovf_cnt, m_ovf, m_cnt); end
            checks++; if (irq_thresh !== e_irq) begin errors++; $display("FAIL rnd_irq[%0d]: got %b want %b", i, irq_thresh, e_irq); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_thresh();
        test_flush_clear();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of byte entries; SHALL be a power of two, minimum 2.
REQ-002 SHALL have localparam AW = clog2(DEPTH), the pointer index width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port rx_valid  input  1  single-cycle pulse from the UART receiver marking a received byte.
REQ-006 SHALL have port rx_data  input  8  received byte; sampled only when rx_valid=1.
REQ-007 SHALL have port cfg_flush  input  1  synchronous flush request.
REQ-008 SHALL have port cfg_thresh  input  AW+1  interrupt fill threshold; 0 disables the interrupt.
REQ-009 SHALL have port ovf_clear  input  1  clears the overrun flag and the drop counter.
REQ-010 SHALL have port out_valid  output  1  head byte available.
REQ-011 SHALL have port out_data  output  8  head byte; valid only while out_valid=1.
REQ-012 SHALL have port out_ready  input  1  consumer accept; a pop occurs when out_valid and out_ready are both 1.
REQ-013 SHALL have port fifo_count  output  AW+1  occupancy, 0..DEPTH.
REQ-014 SHALL have port fifo_full  output  1  fifo_count == DEPTH.
REQ-015 SHALL have port fifo_empty  output  1  fifo_count == 0.
REQ-016 SHALL have port ovf  output  1  sticky overrun flag.
REQ-017 SHALL have port ovf_cnt  output  8  saturating count of dropped bytes.
REQ-018 SHALL have port irq_thresh  output  1  level interrupt: cfg_thresh != 0 and fifo_count >= cfg_thresh.

Function
REQ-019 SHALL be first-word-fall-through: out_data equals the entry at the read pointer whenever out_valid=1.
REQ-020 SHALL define out_valid as !fifo_empty, with all status derived from registered pointers and count.
REQ-021 SHALL have a latency of 1 cycle from an rx_valid push into an empty FIFO to out_valid=1; there is no combinational bypass.
REQ-022 SHALL push when rx_valid=1 and (fifo_full=0 or a pop occurs in the same cycle); when full with a simultaneous pop, push and pop both occur and count stays DEPTH.
REQ-023 SHALL drop the byte when rx_valid=1, fifo_full=1 and no pop; it then sets ovf and increments ovf_cnt, saturating at 255.
REQ-024 SHALL leave count unchanged on a simultaneous push and pop in the non-empty, non-full case.
REQ-025 SHALL make no pop possible on an empty FIFO; out_ready is ignored when out_valid=0.
REQ-026 SHALL use AW+1-bit read and write pointers that wrap modulo 2*DEPTH; storage is indexed by pointer[AW-1:0].
REQ-027 SHALL make cfg_flush zero both pointers and the count at the next edge, taking priority over any same-cycle push or pop; the same-cycle rx byte is discarded and not counted as overrun.
REQ-028 SHALL leave ovf and ovf_cnt unchanged on flush.
REQ-029 SHALL clear ovf and zero ovf_cnt on ovf_clear; if an overrun occurs in the same cycle, the result is ovf=1 and ovf_cnt=1.
REQ-030 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-031 SHALL make irq_thresh combinational from the registered fifo_count and cfg_thresh; a cfg_thresh greater than DEPTH never asserts.

Reset
REQ-032 SHALL, on rst low, asynchronously clear the pointers, count, ovf and ovf_cnt, giving out_valid=0, fifo_empty=1, fifo_full=0, fifo_count=0 and irq_thresh=0.
REQ-033 SHALL not reset the storage array; out_data is don't-care while out_valid=0.
REQ-034 SHALL discard FIFO contents on reset mid-operation; the first rx_valid after deassertion is stored at entry 0.

Structure
REQ-035 SHALL take the byte width constant UART_DATA_W=8 from the shared package uart_pkg, which is also used by the UART receiver and transmitter.
REQ-036 SHALL place storage in a sub-module uart_fifo_mem: a DEPTH x 8 register array with synchronous write and asynchronous read, with no reset.
REQ-037 SHALL keep the pointer, count and overrun logic in uart_rx_fifo.

Verification
REQ-038 SHALL cover basic flow: push 0x55 with out_ready=0 -> out_valid=1 next cycle, out_data=0x55, fifo_count=1; assert out_ready for one cycle -> fifo_empty=1.
REQ-039 SHALL cover fill and overflow: DEPTH=16, push 0x00..0x0F then 0xA0, 0xA1 with no pops -> fifo_full=1, ovf=1, ovf_cnt=2; drain yields 0x00..0x0F in order.
REQ-040 SHALL cover full with a simultaneous pop: when full, pulse rx_valid with 0x77 and out_ready=1 -> 0x00 popped, 0x77 stored last, count=16, ovf stays 0.
REQ-041 SHALL cover the threshold: cfg_thresh=4, push 4 bytes -> irq_thresh rises on the cycle count becomes 4; pop 1 -> irq_thresh=0; cfg_thresh=0 -> never asserts.
REQ-042 SHALL cover flush and clear: with 5 entries and ovf=1, pulse cfg_flush with rx_valid=1 -> count=0, byte discarded, ovf still 1; pulse ovf_clear -> ovf=0, ovf_cnt=0.
REQ-043 SHALL cover reset mid-operation: with 7 entries, pulse rst low -> count=0 immediately; push 0x3C -> read back 0x3C; also a wrap test of 40 push/pop pairs for ordering.
